// File: rtl/arena_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arena_scanner_pkg
// Description : Shared definitions for the arena seeder/evolver/scanner family:
//               FSM state encodings and the row/column index width.
// Revision    : 1.0 - initial release
// ============================================================================
package arena_scanner_pkg;

    // Row and column indices are 10 bits wide, enough for a 1024x1024 arena.
    localparam int IDX_W = 10;

    // Encodings are shared with the seeder and evolver so that state values
    // read the same in every block of the arena family.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        SHIFT = 2'b10
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/arena_scanner_row_shifter.sv
`default_nettype none
// ============================================================================
// Module      : arena_row_shifter
// Description : Parallel-load, shift-left register holding one arena row.
//               The MSB is the cell currently presented (column 0 first).
// Revision    : 1.0 - initial release
// ============================================================================
module arena_row_shifter
    import arena_scanner_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_q;

    // Load has priority; shifting moves the next column into the MSB slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/arena_scanner.sv
`default_nettype none
// ============================================================================
// Module      : arena_scanner
// Description : Walks every arena row, latches its column word and streams
//               the cells out one per transfer over a valid/ready handshake.
//               Optional macro ARENA_SCANNER_POPCOUNT_EN adds a live_count
//               output counting live cells transferred in the current scan.
// Revision    : 1.0 - initial release
// ============================================================================
module arena_scanner
    import arena_scanner_pkg::*;
#(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    output logic [IDX_W-1:0]       arena_row_select,
    input  logic [ARENA_WIDTH-1:0] arena_columns,
    output logic                   cell_valid,
    input  logic                   cell_ready,
    output logic                   cell_data,
    output logic [IDX_W-1:0]       cell_row,
    output logic [IDX_W-1:0]       cell_col,
    output logic                   cell_last
`ifdef ARENA_SCANNER_POPCOUNT_EN
    ,
    output logic [19:0]            live_count
`endif
);

    localparam logic [IDX_W-1:0] c_MAX_COLUMN = IDX_W'(ARENA_WIDTH - 1);
    localparam logic [IDX_W-1:0] c_MAX_ROW    = IDX_W'(ARENA_HEIGHT - 1);
    localparam logic [IDX_W-1:0] c_ONE        = IDX_W'(1);

    scan_state_t      r_state;
    logic             r_ready;
    logic             r_cell_valid;
    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;

    logic w_xfer;
    logic w_col_end;
    logic w_row_end;
    logic w_load;
    logic w_shift;
    logic w_msb;

    assign w_xfer    = r_cell_valid & cell_ready;
    assign w_col_end = (r_col == c_MAX_COLUMN);
    assign w_row_end = (r_row == c_MAX_ROW);
    assign w_load    = (r_state == FETCH);
    // The last column never shifts: the next FETCH reloads the register.
    assign w_shift   = w_xfer & ~w_col_end;

    arena_row_shifter #(
        .WIDTH (ARENA_WIDTH)
    ) u_row_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (arena_columns),
        .o_msb   (w_msb)
    );

    // Scan FSM with row/column counters and registered ready/valid flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_cell_valid <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_ready <= 1'b0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                FETCH: begin
                    r_col        <= '0;
                    r_cell_valid <= 1'b1;
                    r_state      <= SHIFT;
                end
                SHIFT: begin
                    if (w_xfer) begin
                        if (!w_col_end) begin
                            r_col <= r_col + c_ONE;
                        end else if (!w_row_end) begin
                            r_row        <= r_row + c_ONE;
                            r_cell_valid <= 1'b0;
                            r_state      <= FETCH;
                        end else begin
                            r_cell_valid <= 1'b0;
                            r_ready      <= 1'b1;
                            r_state      <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_ready      <= 1'b1;
                    r_cell_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARENA_SCANNER_POPCOUNT_EN
    logic [19:0] r_live_count;

    // Live-cell tally: cleared when a scan starts, held once the scan ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live_count <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_live_count <= '0;
        end else if (w_xfer && w_msb) begin
            r_live_count <= r_live_count + 20'd1;
        end
    end

    assign live_count = r_live_count;
`endif

    assign ready            = r_ready;
    assign arena_row_select = r_row;
    assign cell_valid       = r_cell_valid;
    assign cell_data        = r_cell_valid & w_msb;
    assign cell_row         = r_row;
    assign cell_col         = r_col;
    assign cell_last        = r_cell_valid & w_col_end & w_row_end;

endmodule
`default_nettype wire

// File: tb/tb_arena_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_arena_scanner
// Description : Directed self-checking bench for arena_scanner. A 4x3 arena
//               and a 2x1 arena are scanned with free-flowing and stalling
//               consumers, a mid-scan start and a mid-scan reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arena_scanner;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    logic reset;

    // 4x3 arena instance
    logic       a_start, a_ready, a_valid, a_cready, a_data, a_last;
    logic [9:0] a_rsel, a_row, a_col;
    logic [3:0] a_cols;

    // 2x1 arena instance
    logic       b_start, b_ready, b_valid, b_cready, b_data, b_last;
    logic [9:0] b_rsel, b_row, b_col;
    logic [1:0] b_cols;

`ifdef ARENA_SCANNER_POPCOUNT_EN
    logic [19:0] a_live, b_live;
`endif

    // Expected streams, first cell in the MSB.
    logic [11:0] exp_a = 12'b1010_0001_1111;
    logic [1:0]  exp_b = 2'b10;
    logic [15:0] stall_pat = 16'b1011_0010_1110_0101;

    always #5 clk = ~clk;

    // Arena storage models: row word returned combinationally.
    always_comb begin
        case (a_rsel)
            10'd0:   a_cols = 4'b1010;
            10'd1:   a_cols = 4'b0001;
            10'd2:   a_cols = 4'b1111;
            default: a_cols = 4'b0000;
        endcase
    end
    assign b_cols = (b_rsel == 10'd0) ? 2'b10 : 2'b00;

    arena_scanner #(.ARENA_WIDTH(4), .ARENA_HEIGHT(3)) dut_a (
        .clk              (clk),
        .reset            (reset),
        .start            (a_start),
        .ready            (a_ready),
        .arena_row_select (a_rsel),
        .arena_columns    (a_cols),
        .cell_valid       (a_valid),
        .cell_ready       (a_cready),
        .cell_data        (a_data),
        .cell_row         (a_row),
        .cell_col         (a_col),
        .cell_last        (a_last)
`ifdef ARENA_SCANNER_POPCOUNT_EN
        ,
        .live_count       (a_live)
`endif
    );

    arena_scanner #(.ARENA_WIDTH(2), .ARENA_HEIGHT(1)) dut_b (
        .clk              (clk),
        .reset            (reset),
        .start            (b_start),
        .ready            (b_ready),
        .arena_row_select (b_rsel),
        .arena_columns    (b_cols),
        .cell_valid       (b_valid),
        .cell_ready       (b_cready),
        .cell_data        (b_data),
        .cell_row         (b_row),
        .cell_col         (b_col),
        .cell_last        (b_last)
`ifdef ARENA_SCANNER_POPCOUNT_EN
        ,
        .live_count       (b_live)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full scan of the 4x3 arena. Caller is positioned just after a clock
    // edge with the scanner idle. Every presented cell is compared with the
    // model stream, including during stalls.
    task automatic scan_a(input bit stall, input int mid_start);
        int n, k, stalls, lastc;
        n = 0; k = 0; stalls = 0; lastc = 0;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("a_ready_low", {31'd0, a_ready}, 32'd0);
`ifdef ARENA_SCANNER_POPCOUNT_EN
        chk("a_live_cleared", {12'd0, a_live}, 32'd0);
`endif
        a_cready = stall ? stall_pat[0] : 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            n++;
            a_start = (n == mid_start);
            if (a_ready) break;
            if (a_valid) begin
                if (k >= 12) begin
                    chk("a_extra_cell", k, 32'd11);
                end else begin
                    chk("a_data", {31'd0, a_data}, {31'd0, exp_a[11-k]});
                    chk("a_row",  {22'd0, a_row},  k / 4);
                    chk("a_col",  {22'd0, a_col},  k % 4);
                    chk("a_rsel", {22'd0, a_rsel}, k / 4);
                    chk("a_last", {31'd0, a_last}, (k == 11) ? 32'd1 : 32'd0);
                end
            end
            a_cready = stall ? stall_pat[n % 16] : 1'b1;
            if (a_valid && a_cready) begin
                if (a_last) lastc++;
                k++;
            end else if (a_valid) begin
                stalls++;
            end
        end
        a_start = 1'b0;
        chk("a_scan_cycles", n, 15 + stalls);
        chk("a_cells", k, 32'd12);
        chk("a_last_count", lastc, 32'd1);
        chk("a_valid_idle", {31'd0, a_valid}, 32'd0);
`ifdef ARENA_SCANNER_POPCOUNT_EN
        chk("a_live_final", {12'd0, a_live}, 32'd7);
`endif
    endtask

    initial begin
        int n, k;
        reset = 1'b1;
        a_start = 1'b0; a_cready = 1'b0;
        b_start = 1'b0; b_cready = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_data",  {31'd0, a_data},  32'd0);
        chk("rst_last",  {31'd0, a_last},  32'd0);
        chk("rst_rsel",  {22'd0, a_rsel},  32'd0);
        chk("rst_row",   {22'd0, a_row},   32'd0);
        chk("rst_col",   {22'd0, a_col},   32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
`ifdef ARENA_SCANNER_POPCOUNT_EN
        chk("rst_live", {12'd0, a_live}, 32'd0);
`endif

        // start together with reset: reset wins
        a_start = 1'b1;
        @(posedge clk); #1;
        chk("start_in_reset", {31'd0, a_ready}, 32'd1);
        a_start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // Free-flowing consumer
        scan_a(1'b0, -1);

        // Count holds in idle
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ready", {31'd0, a_ready}, 32'd1);
`ifdef ARENA_SCANNER_POPCOUNT_EN
        chk("live_held", {12'd0, a_live}, 32'd7);
`endif

        // Stalling consumer
        scan_a(1'b1, -1);

        // Start pulsed mid-scan is ignored
        scan_a(1'b0, 6);

        // Reset while presenting (1,2)
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        a_cready = 1'b1;
        k = 0;
        for (int c = 0; c < 50; c++) begin
            if (a_valid && a_row == 10'd1 && a_col == 10'd2) begin
                k = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_1_2", k, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, a_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, a_ready}, 32'd1);
        chk("mid_rst_rsel",  {22'd0, a_rsel},  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        scan_a(1'b0, -1);

        // Single-row 2x1 arena
        b_cready = 1'b1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n = 0; k = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            n++;
            if (b_ready) break;
            if (b_valid) begin
                if (k >= 2) begin
                    chk("b_extra_cell", k, 32'd1);
                end else begin
                    chk("b_data", {31'd0, b_data}, {31'd0, exp_b[1-k]});
                    chk("b_row",  {22'd0, b_row},  32'd0);
                    chk("b_col",  {22'd0, b_col},  k);
                    chk("b_last", {31'd0, b_last}, (k == 1) ? 32'd1 : 32'd0);
                end
                k++;
            end
        end
        chk("b_scan_cycles", n, 32'd3);
        chk("b_cells", k, 32'd2);
`ifdef ARENA_SCANNER_POPCOUNT_EN
        chk("b_live", {12'd0, b_live}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
